hps_pio_in_edge: RTL and testbench
==================================

HPS_PIO_IN_EDGE -- requirements
Module: hps_pio_in_edge

Interface
REQ-001 Parameter WIDTH, default 8, input port width, legal 1..32.
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser depth, legal 2..4.
REQ-003 Parameter EDGE_TYPE, default 0, edge detection mode: 0 = rising, 1 = falling, 2 = any.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 address  input  2  Avalon-MM slave word address.
REQ-007 chipselect  input  1  Avalon-MM slave select.
REQ-008 write_n  input  1  Avalon-MM write strobe, active-low.
REQ-009 writedata  input  32  Avalon-MM write data.
REQ-010 in_port  input  WIDTH  asynchronous external inputs.
REQ-011 readdata  output  32  Avalon-MM read data, registered.
REQ-012 irq  output  1  level interrupt to HPS, active-high.

Function
REQ-013 The block SHALL pass each in_port bit through SYNC_STAGES flops; the last stage is data_in.
REQ-014 The block SHALL keep prev, a one-cycle-delayed copy of data_in.
REQ-015 The per-bit edge term SHALL be data_in&~prev for EDGE_TYPE 0, ~data_in&prev for EDGE_TYPE 1, and data_in^prev for EDGE_TYPE 2.
REQ-016 Register map (readdata zero-extended above WIDTH): 0 = data_in (RO), 1 = reads 0 (writes ignored), 2 = irq_mask (RW), 3 = edge_capture (read / write-1-to-clear).
REQ-017 readdata SHALL update on every clk edge from the address mux, regardless of chipselect, giving read latency 1.
REQ-018 A write is chipselect=1 and write_n=0; address 2 SHALL load irq_mask from writedata[WIDTH-1:0].
REQ-019 A write to address 3 SHALL clear each edge_capture bit whose writedata bit is 1; zero bits are unaffected.
REQ-020 An edge_capture bit SHALL set on the clk edge after its edge term is 1, and SHALL hold until cleared.
REQ-021 If set and clear hit the same bit in the same cycle, set SHALL win and the bit reads 1.
REQ-022 irq SHALL equal OR-reduce(edge_capture & irq_mask), with no extra register stage.
REQ-023 Writing irq_mask SHALL not alter edge_capture; unmasking an already-captured bit SHALL assert irq the next cycle.
REQ-024 Total latency from an in_port transition (sampled at edge k) SHALL be:
  - data_in valid after edge k+SYNC_STAGES-1;
  - edge_capture and irq valid after edge k+SYNC_STAGES.
REQ-025 Arm counter:
  - a saturating counter SHALL gate the edge term to 0 until SYNC_STAGES+1 clk edges after reset deassertion;
  - this prevents spurious captures from inputs already high at reset;
  - the counter is 3 bits and saturates at SYNC_STAGES+1.
REQ-026 Behaviour for WIDTH<32 SHALL be identical per bit; writedata bits at or above WIDTH SHALL be ignored.

Reset
REQ-027 Reset SHALL clear synchroniser flops, prev, irq_mask, edge_capture, the arm counter and readdata to 0, and SHALL force irq to 0.
REQ-028 Reset asserted mid-operation SHALL clear all state immediately, without waiting for clk.
REQ-029 After deassertion the arm window of REQ-025 SHALL restart.

Verification
REQ-030 Reset with in_port=8'hFF held, then release; wait 10 cycles, then read address 3 -> readdata 0, irq 0; read address 0 -> 32'h000000FF.
REQ-031 EDGE_TYPE 0: mask=8'h01, drive in_port 00->01 at edge k -> edge_capture=8'h01 and irq=1 after edge k+2; write 8'h01 to address 3 -> irq=0 the next cycle.
REQ-032 Hold rising edges on bit 3 while writing 8'h08 to address 3 in the same cycle the bit would set -> bit remains 1.
REQ-033 Mask=0, capture bit 5 -> irq=0; write mask 8'h20 -> irq=1 the next cycle; read address 3 -> 32'h00000020.
REQ-034 EDGE_TYPE 2, WIDTH 1: toggle in_port 3 times, clearing the capture after each toggle -> 3 separate captures; reset mid-capture -> all outputs 0 asynchronously.
REQ-035 Read addresses 1 and 2 after writing 32'hFFFFFFFF to both -> address 1 reads 0, address 2 reads 32'h000000FF.

Source files
------------

// File: rtl/hps_pio_in_edge.sv
// Avalon-MM parallel input port with synchronised edge capture and masked level interrupt.
// Edge detection is armed only after the synchroniser has flushed its reset contents.
module hps_pio_in_edge #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned ARM_W   = 3;
    localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [ARM_W-1:0] arm_q, arm_d;
    logic [31:0]      readdata_q, readdata_d;

    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] edge_term;
    logic [WIDTH-1:0] clear_bits;
    logic             wr_en;
    logic             armed;
    logic             unused_wd;

    // Bits of writedata above WIDTH have no destination.
    assign unused_wd = ^writedata;

    // Synchroniser chain and one-cycle history of its output.
    always_comb begin
        sync_d[0] = in_port;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
        data_in = sync_q[SYNC_STAGES-1];
        prev_d  = data_in;
    end

    // Arm window keeps reset-flush transitions from looking like edges.
    always_comb begin
        armed = (arm_q == ARM_MAX);
        arm_d = armed ? arm_q : arm_q + ARM_W'(1);
    end

    always_comb begin
        edge_raw = data_in ^ prev_q;
        if (EDGE_TYPE == 0) begin
            edge_raw = data_in & ~prev_q;
        end else if (EDGE_TYPE == 1) begin
            edge_raw = ~data_in & prev_q;
        end
        edge_term = armed ? edge_raw : '0;
    end

    // Register writes; a same-cycle set beats write-1-to-clear.
    always_comb begin
        wr_en          = chipselect & ~write_n;
        irq_mask_d     = irq_mask_q;
        clear_bits     = '0;
        if (wr_en && (address == 2'd2)) begin
            irq_mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && (address == 2'd3)) begin
            clear_bits = writedata[WIDTH-1:0];
        end
        edge_capture_d = (edge_capture_q & ~clear_bits) | edge_term;
    end

    always_comb begin
        readdata_d = 32'd0;
        case (address)
            2'd0:    readdata_d = 32'(data_in);
            2'd2:    readdata_d = 32'(irq_mask_q);
            2'd3:    readdata_d = 32'(edge_capture_q);
            default: readdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            prev_q         <= '0;
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
            arm_q          <= '0;
            readdata_q     <= 32'd0;
        end else begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_d[i];
            end
            prev_q         <= prev_d;
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            arm_q          <= arm_d;
            readdata_q     <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_hps_pio_in_edge.sv
// Directed bench: an 8-bit rising-edge port driven from a vector table, and a
// 1-bit any-edge port exercised with hand-written toggle and reset sequences.
module tb_hps_pio_in_edge;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic        cs0, cs1;
    logic [7:0]  in0;
    logic [0:0]  in1;
    logic [31:0] rd0, rd1;
    logic        irq0, irq1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hps_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs0),
        .write_n(write_n), .writedata(writedata), .in_port(in0),
        .readdata(rd0), .irq(irq0)
    );

    hps_pio_in_edge #(.WIDTH(1), .SYNC_STAGES(2), .EDGE_TYPE(2)) dut1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs1),
        .write_n(write_n), .writedata(writedata), .in_port(in1),
        .readdata(rd1), .irq(irq1)
    );

    typedef struct {
        logic [1:0]  addr;
        logic        wr;
        logic [31:0] wd;
        logic [7:0]  inp;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one bus cycle at a falling edge; outputs are sampled at the next falling edge.
    task automatic cyc(input logic sel, input logic [1:0] a, input logic wr, input logic [31:0] wd);
        address   = a;
        write_n   = ~wr;
        writedata = wd;
        cs0       = ~sel;
        cs1       = sel;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step1(input string name, input logic [1:0] a, input logic wr,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_irq);
        cyc(1'b1, a, wr, wd);
        chk({name, ".rd"}, rd1, exp_rd);
        chk({name, ".irq"}, 32'(irq1), 32'(exp_irq));
    endtask

    initial begin
        // Rising-edge, 8-bit vectors (applied after reset with in_port held at FF).
        vq.push_back('{2'd3, 1'b0, 32'h0,        8'hFF, 32'h00, 1'b0}); // no spurious capture
        vq.push_back('{2'd0, 1'b0, 32'h0,        8'hFF, 32'hFF, 1'b0});
        vq.push_back('{2'd2, 1'b1, 32'h01,       8'h00, 32'h00, 1'b0}); // mask=01
        vq.push_back('{2'd0, 1'b0, 32'h0,        8'h00, 32'hFF, 1'b0});
        vq.push_back('{2'd0, 1'b0, 32'h0,        8'h00, 32'h00, 1'b0});
        vq.push_back('{2'd3, 1'b0, 32'h0,        8'h01, 32'h00, 1'b0}); // bit0 rises, edge k
        vq.push_back('{2'd3, 1'b0, 32'h0,        8'h01, 32'h00, 1'b0});
        vq.push_back('{2'd3, 1'b0, 32'h0,        8'h01, 32'h00, 1'b1}); // captured at k+2
        vq.push_back('{2'd3, 1'b1, 32'h01,       8'h01, 32'h01, 1'b0}); // clear
        vq.push_back('{2'd3, 1'b0, 32'h0,        8'h01, 32'h00, 1'b0});
        vq.push_back('{2'd3, 1'b0, 32'h0,        8'h09, 32'h00, 1'b0}); // bit3 rises
        vq.push_back('{2'd3, 1'b0, 32'h0,        8'h09, 32'h00, 1'b0});
        vq.push_back('{2'd3, 1'b1, 32'h08,       8'h09, 32'h00, 1'b0}); // set and clear collide
        vq.push_back('{2'd3, 1'b0, 32'h0,        8'h09, 32'h08, 1'b0});
        vq.push_back('{2'd2, 1'b1, 32'h00,       8'h09, 32'h01, 1'b0}); // mask=0
        vq.push_back('{2'd3, 1'b1, 32'hFF,       8'h29, 32'h08, 1'b0}); // clear all, bit5 rises
        vq.push_back('{2'd3, 1'b0, 32'h0,        8'h29, 32'h00, 1'b0});
        vq.push_back('{2'd3, 1'b0, 32'h0,        8'h29, 32'h00, 1'b0}); // captured but masked
        vq.push_back('{2'd2, 1'b1, 32'h20,       8'h29, 32'h00, 1'b1}); // unmask -> irq
        vq.push_back('{2'd3, 1'b0, 32'h0,        8'h29, 32'h20, 1'b1});
        vq.push_back('{2'd1, 1'b1, 32'hFFFFFFFF, 8'h29, 32'h00, 1'b1});
        vq.push_back('{2'd2, 1'b1, 32'hFFFFFFFF, 8'h29, 32'h20, 1'b1});
        vq.push_back('{2'd1, 1'b0, 32'h0,        8'h29, 32'h00, 1'b1});
        vq.push_back('{2'd2, 1'b0, 32'h0,        8'h29, 32'hFF, 1'b1});
        vq.push_back('{2'd3, 1'b1, 32'hFFFFFFFF, 8'h09, 32'h20, 1'b0}); // clear, bit5 falls
        vq.push_back('{2'd3, 1'b0, 32'h0,        8'h09, 32'h00, 1'b0});
        vq.push_back('{2'd3, 1'b0, 32'h0,        8'h09, 32'h00, 1'b0});
        vq.push_back('{2'd3, 1'b0, 32'h0,        8'h09, 32'h00, 1'b0}); // falling ignored
        vq.push_back('{2'd0, 1'b0, 32'h0,        8'h09, 32'h09, 1'b0});

        reset = 1'b1; address = 2'd0; write_n = 1'b1; writedata = 32'd0;
        cs0 = 1'b0; cs1 = 1'b0; in0 = 8'hFF; in1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.rd0", rd0, 32'h0);
        chk("reset.irq0", 32'(irq0), 32'h0);
        chk("reset.rd1", rd1, 32'h0);
        chk("reset.irq1", 32'(irq1), 32'h0);
        reset = 1'b0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end

        foreach (vq[i]) begin
            in0 = vq[i].inp;
            cyc(1'b0, vq[i].addr, vq[i].wr, vq[i].wd);
            chk($sformatf("vec%0d.rd", i), rd0, vq[i].exp_rd);
            chk($sformatf("vec%0d.irq", i), 32'(irq0), 32'(vq[i].exp_irq));
        end

        // 1-bit any-edge port: arm window restarts after a second reset with input high.
        cs0 = 1'b0; write_n = 1'b1;
        in1 = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst2.rd1", rd1, 32'h0);
        reset = 1'b0;
        step1("arm.mask", 2'd2, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step1($sformatf("arm%0d", i), 2'd3, 1'b0, 32'h0, 32'h0, 1'b0);
        end
        step1("arm.data", 2'd0, 1'b0, 32'h0, 32'h1, 1'b0);
        step1("arm.mask_rd", 2'd2, 1'b0, 32'h0, 32'h1, 1'b0);

        // Three toggles, each captured and cleared separately.
        for (int t = 0; t < 3; t++) begin
            in1 = ~in1;
            step1($sformatf("tog%0d.s1", t), 2'd3, 1'b0, 32'h0, 32'h0, 1'b0);
            step1($sformatf("tog%0d.s2", t), 2'd3, 1'b0, 32'h0, 32'h0, 1'b0);
            step1($sformatf("tog%0d.s3", t), 2'd3, 1'b0, 32'h0, 32'h0, 1'b1);
            step1($sformatf("tog%0d.clr", t), 2'd3, 1'b1, 32'h1, 32'h1, 1'b0);
        end

        // Reset between clock edges while a capture is pending.
        in1 = ~in1;
        step1("mid.s1", 2'd3, 1'b0, 32'h0, 32'h0, 1'b0);
        step1("mid.s2", 2'd3, 1'b0, 32'h0, 32'h0, 1'b0);
        step1("mid.s3", 2'd3, 1'b0, 32'h0, 32'h0, 1'b1);
        step1("mid.s4", 2'd3, 1'b0, 32'h0, 32'h1, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("async.rd1", rd1, 32'h0);
        chk("async.irq1", 32'(irq1), 32'h0);
        chk("async.rd0", rd0, 32'h0);
        chk("async.irq0", 32'(irq0), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
